ws2812b_decoder: RTL and testbench



---
 rtl/ws2812b_decoder.sv | 146 ++++++++++++++
 tb/tb_ws2812b_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_decoder.sv
// WS2812B single-wire decoder: classifies high-pulse widths into bits, assembles
// 24-bit GRB pixels with their frame index, and reports latch gaps and line errors.
module ws2812b_decoder #(
  parameter int BIT_THRESHOLD = 7,
  parameter int MAX_HIGH      = 16,
  parameter int RESET_CYCLES  = 600,
  parameter int NUM_PIXELS    = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              din,
  output logic                              pixel_valid,
  output logic [23:0]                       pixel_data,
  output logic [$clog2(NUM_PIXELS)-1:0]     pixel_index,
  output logic                              frame_done,
  output logic [$clog2(NUM_PIXELS+1)-1:0]   frame_pixels,
  output logic                              error
);

  localparam int IDX_W  = $clog2(NUM_PIXELS);
  localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH + 2);
  localparam int LOW_W  = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t             state;
  logic               din_meta;
  logic               din_s;
  logic [HIGH_W-1:0]  high_cnt;
  logic [LOW_W-1:0]   low_cnt;
  logic [4:0]         bit_cnt;
  logic [CNT_W-1:0]   pix_cnt;
  logic [22:0]        shift;
  logic               bit_val;
  logic [23:0]        next_word;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values;
  // blocking assignments here would collapse the two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
    end
  end

  // The bit being closed joins the 23 bits already held to form the full word.
  assign bit_val   = (high_cnt >= HIGH_W'(BIT_THRESHOLD));
  assign next_word = {shift, bit_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC;
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      // NOTE: the shift register is reset too, so a stale partial word never
      // survives a reset into the held pixel_data.
      shift        <= '0;
      pixel_valid  <= 1'b0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      error        <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      case (state)
        // Wait for a full latch gap before trusting bit boundaries.
        SYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt == LOW_W'(RESET_CYCLES - 1)) begin
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (din_s) begin
            high_cnt <= HIGH_W'(1);
            state    <= HIGH;
          end
        end

        HIGH: begin
          if (high_cnt > HIGH_W'(MAX_HIGH)) begin
            error   <= 1'b1;
            bit_cnt <= '0;
            pix_cnt <= '0;
            low_cnt <= '0;
            state   <= SYNC;
          end else if (din_s) begin
            high_cnt <= high_cnt + 1'b1;
          end else begin
            shift   <= next_word[22:0];
            low_cnt <= LOW_W'(1);
            state   <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt < CNT_W'(NUM_PIXELS)) begin
                pixel_valid <= 1'b1;
                pixel_data  <= next_word;
                pixel_index <= pix_cnt[IDX_W-1:0];
                pix_cnt     <= pix_cnt + 1'b1;
              end else begin
                error <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        LOW: begin
          if (din_s) begin
            high_cnt <= HIGH_W'(1);
            state    <= HIGH;
          end else if (low_cnt == LOW_W'(RESET_CYCLES - 1)) begin
            frame_done   <= 1'b1;
            frame_pixels <= pix_cnt;
            error        <= (bit_cnt != 5'd0);
            pix_cnt      <= '0;
            bit_cnt      <= '0;
            low_cnt      <= '0;
            state        <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Bench for ws2812b_decoder: pulse-level stimulus, an event-schedule model derived
// from pulse widths and gap lengths, and a per-cycle compare against that schedule.
module tb_ws2812b_decoder;

  localparam int BIT_THRESHOLD = 7;
  localparam int MAX_HIGH      = 16;
  localparam int RESET_CYCLES  = 600;
  localparam int NUM_PIXELS    = 64;
  localparam int IW            = $clog2(NUM_PIXELS);
  localparam int FW            = $clog2(NUM_PIXELS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din = 1'b0;
  logic          pixel_valid;
  logic [23:0]   pixel_data;
  logic [IW-1:0] pixel_index;
  logic          frame_done;
  logic [FW-1:0] frame_pixels;
  logic          error;

  ws2812b_decoder #(
    .BIT_THRESHOLD(BIT_THRESHOLD),
    .MAX_HIGH(MAX_HIGH),
    .RESET_CYCLES(RESET_CYCLES),
    .NUM_PIXELS(NUM_PIXELS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .pixel_valid(pixel_valid),
    .pixel_data(pixel_data),
    .pixel_index(pixel_index),
    .frame_done(frame_done),
    .frame_pixels(frame_pixels),
    .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Expected output events, keyed by the clock edge after which they are visible.
  typedef struct {
    logic        pv;
    logic [23:0] data;
    int          idx;
    logic        fd;
    int          fp;
    logic        err;
  } ev_t;

  ev_t exp_q [int];

  function automatic ev_t get_ev(input int c);
    ev_t e;
    e = '{default: '0};
    if (exp_q.exists(c)) e = exp_q[c];
    return e;
  endfunction

  task automatic add_pv(input int c, input logic [23:0] d, input int idx);
    ev_t e;
    e = get_ev(c); e.pv = 1'b1; e.data = d; e.idx = idx; exp_q[c] = e;
  endtask

  task automatic add_fd(input int c, input int fp);
    ev_t e;
    e = get_ev(c); e.fd = 1'b1; e.fp = fp; exp_q[c] = e;
  endtask

  task automatic add_err(input int c);
    ev_t e;
    e = get_ev(c); e.err = 1'b1; exp_q[c] = e;
  endtask

  // Protocol-level model state.
  bit          synced = 1'b0;
  int          bits = 0;
  int          pix = 0;
  logic [23:0] word = '0;
  int          last_fall = 0;
  bit          tent_valid = 1'b0;
  int          tent_cyc = 0;

  // Called at the rising edge of a pulse whose width is already known.
  task automatic model_pulse(input int r, input int h);
    int f;
    f = r + h;
    if (synced) begin
      if (tent_valid) begin
        if (r - last_fall >= RESET_CYCLES) begin
          bits = 0;
          pix  = 0;
        end else begin
          exp_q.delete(tent_cyc);
        end
      end
    end else if (r - last_fall >= RESET_CYCLES + 10) begin
      synced = 1'b1;
    end
    tent_valid = 1'b0;
    last_fall  = f;
    if (synced) begin
      if (h > MAX_HIGH) begin
        add_err(r + MAX_HIGH + 4);
        synced = 1'b0;
        bits   = 0;
        pix    = 0;
      end else begin
        word = {word[22:0], h >= BIT_THRESHOLD};
        bits++;
        if (bits == 24) begin
          bits = 0;
          if (pix < NUM_PIXELS) begin
            add_pv(f + 3, word, pix);
            pix++;
          end else begin
            add_err(f + 3);
          end
        end
        // Frame close if the line then stays low long enough; withdrawn on an early rise.
        tent_cyc   = f + RESET_CYCLES + 2;
        tent_valid = 1'b1;
        add_fd(tent_cyc, pix);
        if (bits != 0) add_err(tent_cyc);
      end
    end
  endtask

  // Expected held values and DUT observations.
  bit          chk_en = 1'b0;
  logic [23:0] hold_data = '0;
  int          hold_idx = 0;
  int          hold_fp = 0;
  int          n_pv = 0, n_fd = 0, n_err = 0;
  int          last_pv_cyc = 0, last_fd_cyc = 0, last_err_cyc = 0;
  logic [23:0] obs_data = '0;
  int          obs_idx = 0, obs_fp = 0;
  ev_t         cur;

  always @(negedge clk) begin
    if (chk_en) begin
      cur = get_ev(cyc);
      exp_q.delete(cyc);
      if (cur.pv) begin
        hold_data = cur.data;
        hold_idx  = cur.idx;
      end
      if (cur.fd) hold_fp = cur.fp;
      check("pixel_valid", 32'(pixel_valid), 32'(cur.pv));
      check("frame_done", 32'(frame_done), 32'(cur.fd));
      check("error", 32'(error), 32'(cur.err));
      check("pixel_data", 32'(pixel_data), 32'(hold_data));
      check("pixel_index", 32'(pixel_index), hold_idx);
      check("frame_pixels", 32'(frame_pixels), hold_fp);
      if (pixel_valid === 1'b1) begin
        n_pv++; last_pv_cyc = cyc; obs_data = pixel_data; obs_idx = int'(pixel_index);
      end
      if (frame_done === 1'b1) begin
        n_fd++; last_fd_cyc = cyc; obs_fp = int'(frame_pixels);
      end
      if (error === 1'b1) begin
        n_err++; last_err_cyc = cyc;
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    int r;
    int ll;
    @(posedge clk); #1;
    din = 1'b1;
    r = cyc;
    model_pulse(r, h);
    ll = l;
    if (!synced && ll >= RESET_CYCLES - 10 && ll < RESET_CYCLES + 10) ll = RESET_CYCLES + 20;
    repeat (h - 1) @(posedge clk);
    @(posedge clk); #1;
    din = 1'b0;
    repeat (ll - 1) @(posedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] d, input int h1, input int l1,
                            input int h0, input int l0);
    for (int b = 23; b >= 0; b--) begin
      if (d[b]) pulse(h1, l1);
      else      pulse(h0, l0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    din   = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    hold_data = '0; hold_idx = 0; hold_fp = 0;
    synced = 1'b0; bits = 0; pix = 0; tent_valid = 1'b0;
    chk_en = 1'b1;
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_pixel_data", 32'(pixel_data), 32'd0);
    check("rst_pixel_index", 32'(pixel_index), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_pixels", 32'(frame_pixels), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    last_fall = cyc;
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1);
  end

  initial begin
    int pv0, fd0, err0, f0, h, l, k;
    do_reset();
    gap(RESET_CYCLES + 20);

    // Single pixel.
    pv0 = n_pv;
    send_pixel(24'h00FF00, 10, 5, 5, 10);
    f0 = last_fall;
    gap(20);
    check("sp_count", n_pv - pv0, 1);
    check("sp_data", 32'(obs_data), 32'h00FF00);
    check("sp_index", obs_idx, 0);
    check("sp_latency", last_pv_cyc - f0, 3);
    check("sp_model_data", 32'(hold_data), 32'h00FF00);
    gap(RESET_CYCLES + 20);

    // Full frame.
    pv0 = n_pv; fd0 = n_fd; err0 = n_err;
    for (int i = 0; i < NUM_PIXELS; i++) send_pixel(24'(i * 24'h010101), 10, 5, 5, 10);
    gap(RESET_CYCLES + 20);
    check("ff_pixels", n_pv - pv0, 64);
    check("ff_last_index", obs_idx, 63);
    check("ff_last_data", 32'(obs_data), 32'h3F3F3F);
    check("ff_frame_done", n_fd - fd0, 1);
    check("ff_frame_pixels", obs_fp, 64);
    check("ff_no_error", n_err - err0, 0);

    // Threshold boundary: 7-cycle highs are ones, 6-cycle highs are zeros.
    send_pixel(24'hAAAAAA, 7, 5, 6, 5);
    gap(20);
    check("thr_data", 32'(obs_data), 32'hAAAAAA);
    gap(RESET_CYCLES + 20);

    // Partial pixel closed by a latch gap.
    pv0 = n_pv; fd0 = n_fd; err0 = n_err;
    for (int b = 0; b < 12; b++) pulse((b % 3 == 0) ? 10 : 5, 8);
    f0 = last_fall;
    gap(RESET_CYCLES + 20);
    check("part_no_pixel", n_pv - pv0, 0);
    check("part_frame_done", n_fd - fd0, 1);
    check("part_error", n_err - err0, 1);
    check("part_same_cycle", last_fd_cyc, last_err_cyc);
    check("part_fd_latency", last_fd_cyc - f0, RESET_CYCLES + 2);
    check("part_frame_pixels", obs_fp, 0);

    // Stuck high mid-pixel, then ignored pulses until a full gap.
    pv0 = n_pv; fd0 = n_fd; err0 = n_err;
    for (int b = 0; b < 5; b++) pulse(10, 5);
    pulse(MAX_HIGH + 1, 5);
    for (int b = 0; b < 6; b++) pulse(10, 5);
    gap(RESET_CYCLES + 20);
    check("stuck_error", n_err - err0, 1);
    check("stuck_no_pixel", n_pv - pv0, 0);
    check("stuck_no_frame_done", n_fd - fd0, 0);
    send_pixel(24'h5A0F3C, 10, 5, 5, 10);
    gap(20);
    check("stuck_next_index", obs_idx, 0);
    check("stuck_next_data", 32'(obs_data), 32'h5A0F3C);
    gap(RESET_CYCLES + 20);

    // Overflow: 65 pixels in one frame.
    pv0 = n_pv; fd0 = n_fd; err0 = n_err;
    for (int i = 0; i <= NUM_PIXELS; i++) send_pixel(24'(i * 24'h030507), 8, 2, 2, 8);
    gap(RESET_CYCLES + 20);
    check("ovf_pixels", n_pv - pv0, 64);
    check("ovf_error", n_err - err0, 1);
    check("ovf_frame_pixels", obs_fp, 64);
    check("ovf_frame_done", n_fd - fd0, 1);

    // Reset during bit 10, then decoding only after a fresh gap.
    for (int b = 0; b < 9; b++) pulse(10, 5);
    @(posedge clk); #1;
    din = 1'b1;
    gap(3);
    do_reset();
    pv0 = n_pv;
    gap(100);
    send_pixel(24'hFFFFFF, 10, 5, 5, 10);
    gap(RESET_CYCLES + 20);
    check("rst_ignored", n_pv - pv0, 0);
    send_pixel(24'h123456, 10, 5, 5, 10);
    gap(20);
    check("rst_resume_count", n_pv - pv0, 1);
    check("rst_resume_index", obs_idx, 0);
    check("rst_resume_data", 32'(obs_data), 32'h123456);

    // Randomized pulse stream against the model.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 39));
      if (k == 0) h = int'($urandom_range(MAX_HIGH + 1, MAX_HIGH + 6));
      else        h = int'($urandom_range(1, MAX_HIGH));
      if (k == 1 || k == 2) begin
        case ($urandom_range(0, 3))
          0:       l = RESET_CYCLES - 1;
          1:       l = RESET_CYCLES;
          2:       l = RESET_CYCLES + 1;
          default: l = RESET_CYCLES + 20;
        endcase
      end else begin
        l = int'($urandom_range(1, 12));
      end
      pulse(h, l);
    end
    gap(RESET_CYCLES + 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
